dp_coeff_ram: RTL and testbench
===============================

# dp_coeff_ram

Parametrised true dual-port coefficient RAM for the Dilithium datapath, the next generation of the fixed 24x256 coefficient store. Each port independently reads or writes one word per cycle with registered read data and a valid flag. A built-in clear engine zeroes the whole array after reset or on request, and same-address write collisions are detected and flagged. It feeds the NTT butterfly and polynomial arithmetic units, which address it two coefficients at a time.

## Interface
Parameters:
- DATA_W, 24, word width in bits (must be ≥1)
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W (must be ≥1)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- clear_i  in  1  one-cycle request to zero the array
- a_en_i / b_en_i  in  1  port A/B access enable
- a_we_i / b_we_i  in  1  write enable; qualified by the port's en
- a_addr_i / b_addr_i  in  ADDR_W  word address
- a_wdata_i / b_wdata_i  in  DATA_W  write data
- a_rdata_o / b_rdata_o  out  DATA_W  registered read data
- a_rvalid_o / b_rvalid_o  out  1  read data valid strobe
- busy_o  out  1  clear engine active; port requests ignored
- collision_o  out  1  one-cycle pulse: both ports wrote the same address

## Operation
- FSM states: CLEAR, READY.
- Reset: state←CLEAR, clear pointer←0. Reset values: rdata 0, rvalid 0, collision_o 0, busy_o 1.
- CLEAR: each cycle writes 0 to entries 2·ptr and 2·ptr+1, ptr++. The last pair written → READY. ADDR_W=1 clears in one cycle. busy_o=1 throughout. en/we ignored, rvalid 0, rdata holds.
- READY: busy_o=0. Port op = en & we → write; en & !we → read; !en → idle.
- Read semantics are read-first. A read at an address written in the same cycle (by either port) returns the old content.
- Write collision: both ports write the same address in the same cycle. Port B's data is stored and collision_o pulses the next cycle. Same-address read+write or read+read is not a collision.
- clear_i in READY: → CLEAR with ptr←0 next cycle. Any same-cycle port requests are dropped (no write, no rvalid). clear_i while in CLEAR is ignored; the clear does not restart.
- rst_i at any point (including mid-clear) overrides everything and restarts the clear from ptr 0.
- Idle port: rvalid 0, rdata holds last read value.

## Timing
- Read latency L=1 cycle (2 with DPRAM_OUTREG_EN). Read accepted at edge n → rdata/rvalid valid after edge n+L; rvalid is high for exactly one cycle per read.
- Back-to-back reads on each port every cycle; throughput is 2 words/cycle.
- Write is visible to a read issued on the following cycle.
- Clear duration: DEPTH/2 cycles, counted from the first edge with rst_i low (or the edge after clear_i). busy_o falls on the edge that completes the last pair.
- collision_o is registered: 1 cycle after the colliding write, and it is unaffected by DPRAM_OUTREG_EN.

## Configuration
- DPRAM_OUTREG_EN defined: adds a second output register stage on rdata and rvalid per port. L=2, and rst_i resets both stages. Pipelined reads and the read-first value are unchanged, only delayed 1 cycle. An in-flight rvalid in stage 2 still completes when clear_i is taken.
- DPRAM_OUTREG_EN undefined: single register stage, L=1.

## Test plan
- Reset, ADDR_W=8: release rst_i → busy_o high exactly 128 cycles, then low. Read every address → all 0 with rvalid.
- Write A addr 0x10=0x7FE001, next cycle read A 0x10 → 0x7FE001 with rvalid 1 cycle later (2 with macro). Same cycle, B read 0x11 → 0.
- Same-cycle A write 0x20=0x000123, B read 0x20 (old 0x0) → B rdata 0x0; a read of 0x20 the next cycle → 0x000123.
- A writes 0x30=0x1, B writes 0x30=0x2 → collision_o high one cycle after; read 0x30 → 0x2. Different addresses → no pulse.
- Fill memory with nonzero values. Pulse clear_i alongside an A write to 0x40 → write dropped, busy_o 128 cycles. A second clear_i mid-clear does not extend it; afterwards all entries are 0.
- Assert rst_i for 1 cycle at clear ptr=60 → the clear restarts and busy_o lasts 128 cycles from release. Outputs are 0 during reset.

Source files
------------

// File: rtl/dp_coeff_ram.sv
// dp_coeff_ram: true dual-port coefficient RAM with a built-in clear engine.
// Define DPRAM_OUTREG_EN for a second read output stage (latency 2).
module dp_coeff_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              a_en_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic              a_rvalid_o,
  input  logic              b_en_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              b_rvalid_o,
  output logic              busy_o,
  output logic              collision_o
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int PTR_W = (ADDR_W > 1) ? ADDR_W - 1 : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH / 2 - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              clearing, accept;
  logic              a_wr, a_rd, b_wr, b_rd;
  logic [ADDR_W-1:0] clr_lo, clr_hi;
  logic              a_v1, b_v1, coll_q;
  logic [DATA_W-1:0] a_d1, b_d1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = READY;
          ptr_d   = '0;
        end
      end
      READY: begin
        if (clear_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // A clear request drops any same-cycle port traffic
  assign clearing = (state_q == CLEAR) && !rst_i;
  assign accept   = (state_q == READY) && !clear_i && !rst_i;
  assign a_wr     = accept && a_en_i && a_we_i;
  assign a_rd     = accept && a_en_i && !a_we_i;
  assign b_wr     = accept && b_en_i && b_we_i;
  assign b_rd     = accept && b_en_i && !b_we_i;
  assign clr_lo   = ADDR_W'({ptr_q, 1'b0});
  assign clr_hi   = clr_lo | ADDR_W'(1);

  // Port B is written last so it wins a same-address collision
  always_ff @(posedge clk_i) begin
    if (clearing) begin
      mem[clr_lo] <= '0;
      mem[clr_hi] <= '0;
    end else begin
      if (a_wr) mem[a_addr_i] <= a_wdata_i;
      if (b_wr) mem[b_addr_i] <= b_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_v1   <= 1'b0;
      b_v1   <= 1'b0;
      a_d1   <= '0;
      b_d1   <= '0;
      coll_q <= 1'b0;
    end else begin
      a_v1   <= a_rd;
      b_v1   <= b_rd;
      coll_q <= a_wr && b_wr && (a_addr_i == b_addr_i);
      if (a_rd) a_d1 <= mem[a_addr_i];
      if (b_rd) b_d1 <= mem[b_addr_i];
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic              a_v2, b_v2;
  logic [DATA_W-1:0] a_d2, b_d2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_v2 <= 1'b0;
      b_v2 <= 1'b0;
      a_d2 <= '0;
      b_d2 <= '0;
    end else begin
      a_v2 <= a_v1;
      b_v2 <= b_v1;
      a_d2 <= a_d1;
      b_d2 <= b_d1;
    end
  end

  assign a_rdata_o  = a_d2;
  assign a_rvalid_o = a_v2;
  assign b_rdata_o  = b_d2;
  assign b_rvalid_o = b_v2;
`else
  assign a_rdata_o  = a_d1;
  assign a_rvalid_o = a_v1;
  assign b_rdata_o  = b_d1;
  assign b_rvalid_o = b_v1;
`endif

  assign busy_o      = (state_q == CLEAR);
  assign collision_o = coll_q;

endmodule

// File: tb/tb_dp_coeff_ram.sv
// tb_dp_coeff_ram: directed and randomized checks of dp_coeff_ram
// against a behavioural dual-port memory model.
`timescale 1ns/1ps
module tb_dp_coeff_ram;
  localparam int DW    = 24;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int HALF  = 128;
`ifdef DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid, busy, coll;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left = 0;
  logic          s1_v [2], s2_v [2];
  logic [DW-1:0] s1_d [2], s2_d [2];
  logic          coll_m = 1'b0;

  always #5 clk = ~clk;

  dp_coeff_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_rdata_o(a_rdata), .a_rvalid_o(a_rvalid),
    .b_en_i(b_en), .b_we_i(b_we), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_rdata_o(b_rdata), .b_rvalid_o(b_rvalid),
    .busy_o(busy), .collision_o(coll)
  );

  function automatic logic e_v(int p);
    return (LAT == 2) ? s2_v[p] : s1_v[p];
  endfunction

  function automatic logic [DW-1:0] e_d(int p);
    return (LAT == 2) ? s2_d[p] : s1_d[p];
  endfunction

  task automatic set_a(logic en, logic we, logic [AW-1:0] ad, logic [DW-1:0] d);
    a_en = en; a_we = we; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(logic en, logic we, logic [AW-1:0] ad, logic [DW-1:0] d);
    b_en = en; b_we = we; b_addr = ad; b_wdata = d;
  endtask

  task automatic idle();
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
  endtask

  // Advance the model by one edge from the currently driven inputs,
  // then clock the DUT and settle past the edge.
  task automatic step();
    if (rst) begin
      clr_left = HALF;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      for (int p = 0; p < 2; p++) begin
        s1_v[p] = 0; s2_v[p] = 0; s1_d[p] = '0; s2_d[p] = '0;
      end
      coll_m = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        s2_v[p] = s1_v[p]; s2_d[p] = s1_d[p]; s1_v[p] = 0;
      end
      coll_m = 0;
      if (clr_left > 0) begin
        clr_left--;
      end else if (clr) begin
        clr_left = HALF;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end else begin
        if (a_en && !a_we) begin s1_v[0] = 1; s1_d[0] = mem_m[a_addr]; end
        if (b_en && !b_we) begin s1_v[1] = 1; s1_d[1] = mem_m[b_addr]; end
        if (a_en && a_we) mem_m[a_addr] = a_wdata;
        if (b_en && b_we) mem_m[b_addr] = b_wdata;
        coll_m = a_en && a_we && b_en && b_we && (a_addr == b_addr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1; idle(); step(); step();
    checks++;
    if (a_rdata !== '0 || b_rdata !== '0) begin
      failures++;
      $display("FAIL reset_rdata a=%h b=%h exp=0", a_rdata, b_rdata);
    end
    checks++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || coll !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags av=%b bv=%b coll=%b busy=%b exp 0 0 0 1",
               a_rvalid, b_rvalid, coll, busy);
    end
    rst = 0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin step(); n++; end
    checks++;
    if (n !== HALF) begin
      failures++;
      $display("FAIL reset_busy_len got=%0d exp=%0d", n, HALF);
    end
    n = 0;
    for (int k = 0; k < HALF + LAT; k++) begin
      if (k < HALF) begin
        set_a(1, 0, AW'(2 * k), '0);
        set_b(1, 0, AW'(2 * k + 1), '0);
      end else idle();
      step();
      if (a_rvalid === 1'b1) n++;
      if (b_rvalid === 1'b1) n++;
      checks++;
      if (a_rvalid !== e_v(0) || a_rdata !== e_d(0) ||
          b_rvalid !== e_v(1) || b_rdata !== e_d(1)) begin
        failures++;
        $display("FAIL reset_readall k=%0d a=%b/%h b=%b/%h exp a=%b/%h b=%b/%h",
                 k, a_rvalid, a_rdata, b_rvalid, b_rdata,
                 e_v(0), e_d(0), e_v(1), e_d(1));
      end
    end
    checks++;
    if (n !== DEPTH) begin
      failures++;
      $display("FAIL reset_readall_count got=%0d exp=%0d", n, DEPTH);
    end
  endtask

  task automatic test_write_read();
    set_a(1, 1, 8'h10, 24'h7FE001); set_b(0, 0, '0, '0); step();
    set_a(1, 0, 8'h10, '0); set_b(1, 0, 8'h11, '0); step();
    idle();
    repeat (LAT - 1) step();
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 24'h7FE001) begin
      failures++;
      $display("FAIL wr_rd_a got=%b/%h exp=1/7fe001", a_rvalid, a_rdata);
    end
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 24'h0) begin
      failures++;
      $display("FAIL wr_rd_b got=%b/%h exp=1/000000", b_rvalid, b_rdata);
    end
    step();
    checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 24'h7FE001) begin
      failures++;
      $display("FAIL wr_rd_hold got=%b/%h exp=0/7fe001", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_read_first();
    set_a(1, 1, 8'h20, 24'h000123); set_b(1, 0, 8'h20, '0); step();
    idle();
    repeat (LAT - 1) step();
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 24'h0) begin
      failures++;
      $display("FAIL read_first_old got=%b/%h exp=1/000000", b_rvalid, b_rdata);
    end
    set_a(1, 0, 8'h20, '0); step();
    idle();
    repeat (LAT - 1) step();
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 24'h000123) begin
      failures++;
      $display("FAIL read_first_new got=%b/%h exp=1/000123", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_collision();
    set_a(1, 1, 8'h30, 24'h1); set_b(1, 1, 8'h30, 24'h2); step();
    idle();
    checks++;
    if (coll !== 1'b1) begin
      failures++;
      $display("FAIL coll_pulse got=%b exp=1", coll);
    end
    step();
    checks++;
    if (coll !== 1'b0) begin
      failures++;
      $display("FAIL coll_one_cycle got=%b exp=0", coll);
    end
    set_a(1, 0, 8'h30, '0); step();
    idle();
    repeat (LAT - 1) step();
    checks++;
    if (a_rdata !== 24'h2) begin
      failures++;
      $display("FAIL coll_b_wins got=%h exp=000002", a_rdata);
    end
    set_a(1, 1, 8'h31, 24'h5); set_b(1, 1, 8'h32, 24'h6); step();
    idle();
    checks++;
    if (coll !== 1'b0) begin
      failures++;
      $display("FAIL coll_diff_addr got=%b exp=0", coll);
    end
    set_a(1, 0, 8'h31, '0); set_b(1, 1, 8'h31, 24'h9); step();
    idle();
    checks++;
    if (coll !== 1'b0) begin
      failures++;
      $display("FAIL coll_rd_wr got=%b exp=0", coll);
    end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < HALF; i++) begin
      set_a(1, 1, AW'(2 * i), DW'($urandom) | 24'h1);
      set_b(1, 1, AW'(2 * i + 1), DW'($urandom) | 24'h1);
      step();
    end
    clr = 1; set_a(1, 1, 8'h40, 24'h55); set_b(0, 0, '0, '0); step();
    clr = 0; idle();
    checks++;
    if (busy !== 1'b1 || a_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL clear_start busy=%b av=%b exp 1 0", busy, a_rvalid);
    end
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (n == 50) clr = 1;
      step();
      clr = 0;
      n++;
    end
    checks++;
    if (n !== HALF) begin
      failures++;
      $display("FAIL clear_busy_len got=%0d exp=%0d", n, HALF);
    end
    n = 0;
    for (int k = 0; k < HALF + LAT; k++) begin
      if (k < HALF) begin
        set_a(1, 0, AW'(2 * k), '0);
        set_b(1, 0, AW'(2 * k + 1), '0);
      end else idle();
      step();
      if (a_rvalid === 1'b1) n++;
      if (b_rvalid === 1'b1) n++;
      checks++;
      if ((a_rvalid === 1'b1 && a_rdata !== '0) ||
          (b_rvalid === 1'b1 && b_rdata !== '0)) begin
        failures++;
        $display("FAIL clear_zero k=%0d a=%h b=%h exp=0", k, a_rdata, b_rdata);
      end
    end
    checks++;
    if (n !== DEPTH) begin
      failures++;
      $display("FAIL clear_read_count got=%0d exp=%0d", n, DEPTH);
    end
  endtask

  task automatic test_rst_mid();
    int n;
    set_a(1, 1, 8'h05, 24'h0ABCDE); step();
    set_a(1, 0, 8'h05, '0); step();
    idle();
    repeat (LAT - 1) step();
    checks++;
    if (a_rdata !== 24'h0ABCDE) begin
      failures++;
      $display("FAIL rst_mid_pre got=%h exp=0abcde", a_rdata);
    end
    clr = 1; step(); clr = 0;
    repeat (60) step();
    rst = 1; step();
    checks++;
    if (a_rdata !== '0 || a_rvalid !== 1'b0 || busy !== 1'b1 || coll !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_outs rd=%h av=%b busy=%b coll=%b exp 0 0 1 0",
               a_rdata, a_rvalid, busy, coll);
    end
    rst = 0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin step(); n++; end
    checks++;
    if (n !== HALF) begin
      failures++;
      $display("FAIL rst_mid_busy_len got=%0d exp=%0d", n, HALF);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      logic nar;
      nar = ($urandom_range(1) == 0);
      set_a($urandom_range(3) != 0, $urandom_range(1) == 1,
            nar ? AW'($urandom_range(3)) : AW'($urandom), DW'($urandom));
      set_b($urandom_range(3) != 0, $urandom_range(1) == 1,
            nar ? AW'($urandom_range(3)) : AW'($urandom), DW'($urandom));
      clr = ($urandom_range(299) == 0);
      step();
      clr = 0;
      checks++;
      if (a_rvalid !== e_v(0) || a_rdata !== e_d(0) ||
          b_rvalid !== e_v(1) || b_rdata !== e_d(1) ||
          coll !== coll_m || busy !== (clr_left > 0)) begin
        failures++;
        $display("FAIL random k=%0d a=%b/%h b=%b/%h c=%b bz=%b exp a=%b/%h b=%b/%h c=%b bz=%b",
                 k, a_rvalid, a_rdata, b_rvalid, b_rdata, coll, busy,
                 e_v(0), e_d(0), e_v(1), e_d(1), coll_m, clr_left > 0);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_first();
    test_collision();
    test_clear();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
